// File: rtl/extreme_val_pkg.sv
// Shared constants and the compare rule for the extreme-value tree.
// Values are widened to CMP_W by the caller so one compare serves every entry width.
package extreme_val_pkg;

  localparam logic MODE_MIN = 1'b0;
  localparam logic MODE_MAX = 1'b1;

  // Wide enough for any entry up to 64 bits plus an extension bit.
  localparam int CMP_W = 65;

  // Returns 1 when challenger b strictly beats incumbent a, so ties stay with a.
  function automatic logic cmp_win(
    input logic [CMP_W-1:0] a,
    input logic [CMP_W-1:0] b,
    input logic             mode,
    input logic             signed_en
  );
    logic lt;
    logic gt;
    if (signed_en) begin
      lt = $signed(b) < $signed(a);
      gt = $signed(b) > $signed(a);
    end else begin
      lt = b < a;
      gt = b > a;
    end
    return (mode == MODE_MAX) ? gt : lt;
  endfunction

endpackage

// File: rtl/extreme_val_node.sv
// Combinational compare-select of two {val, idx, vld} children.
// Child a carries the lower index; it keeps the slot unless b strictly beats it.
module extreme_val_node
  import extreme_val_pkg::*;
#(
  parameter int DATA_SZ = 4,
  parameter int IDX_SZ  = 3,
  parameter int SIGNED  = 0
) (
  input  logic [DATA_SZ-1:0] a_val_i,
  input  logic [IDX_SZ-1:0]  a_idx_i,
  input  logic               a_vld_i,
  input  logic [DATA_SZ-1:0] b_val_i,
  input  logic [IDX_SZ-1:0]  b_idx_i,
  input  logic               b_vld_i,
  input  logic               mode_i,
  output logic [DATA_SZ-1:0] y_val_o,
  output logic [IDX_SZ-1:0]  y_idx_o,
  output logic               y_vld_o
);

  logic [CMP_W-1:0] a_ext;
  logic [CMP_W-1:0] b_ext;
  logic             b_wins;

  generate
    if (SIGNED != 0) begin : g_sext
      assign a_ext = CMP_W'($signed(a_val_i));
      assign b_ext = CMP_W'($signed(b_val_i));
    end else begin : g_zext
      assign a_ext = CMP_W'(a_val_i);
      assign b_ext = CMP_W'(b_val_i);
    end
  endgenerate

  always_comb begin
    b_wins  = b_vld_i;
    if (a_vld_i && b_vld_i) begin
      b_wins = cmp_win(a_ext, b_ext, mode_i, SIGNED != 0);
    end
    y_vld_o = a_vld_i | b_vld_i;
    y_val_o = '0;
    y_idx_o = '0;
    if (b_wins) begin
      y_val_o = b_val_i;
      y_idx_o = b_idx_i;
    end else if (a_vld_i) begin
      y_val_o = a_val_i;
      y_idx_o = a_idx_i;
    end
  end

endmodule

// File: rtl/extreme_val_pipe.sv
// Pipelined arg-min/arg-max over N = 2^(LEVEL-1) masked entries, one register stage per tree level.
// Nodes are heap-numbered: root is 1, node n has children 2n and 2n+1, leaves are N..2N-1.
module extreme_val_pipe
  import extreme_val_pkg::*;
#(
  parameter  int LEVEL   = 4,
  parameter  int DATA_SZ = 4,
  parameter  int SIGNED  = 0,
  localparam int N       = 1 << (LEVEL - 1),
  localparam int IDX_SZ  = LEVEL - 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*DATA_SZ-1:0] in_raw,
  input  logic [N-1:0]         in_mask,
  input  logic                 in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_SZ-1:0]   out_result,
  output logic [IDX_SZ-1:0]    out_idx,
  output logic                 out_found
);

  // Mode is only needed by stages that still feed a later node level.
  localparam int MW = (LEVEL > 2) ? LEVEL - 2 : 1;

  logic [DATA_SZ-1:0] val_q [N-1:1];
  logic [DATA_SZ-1:0] val_d [N-1:1];
  logic [IDX_SZ-1:0]  idx_q [N-1:1];
  logic [IDX_SZ-1:0]  idx_d [N-1:1];
  logic [N-1:1]       vld_q;
  logic [N-1:1]       vld_d;
  logic [LEVEL-1:1]   sv_q;
  logic [MW:1]        mode_q;
  logic               adv;

  assign adv        = !sv_q[LEVEL-1] || out_ready;
  assign in_ready   = adv;
  assign out_valid  = sv_q[LEVEL-1];
  assign out_result = val_q[1];
  assign out_idx    = idx_q[1];
  assign out_found  = vld_q[1];

  genvar gi;
  generate
    for (gi = 1; gi < N; gi++) begin : g_node
      // Stage that registers this node: leaves' parents are stage 1, the root is stage LEVEL-1.
      localparam int K = LEVEL - $clog2(gi + 1);

      logic [DATA_SZ-1:0] a_val, b_val, y_val;
      logic [IDX_SZ-1:0]  a_idx, b_idx, y_idx;
      logic               a_vld, b_vld, y_vld, mode;

      if (2 * gi >= N) begin : g_leaf
        assign a_val = in_raw[(2*gi-N)*DATA_SZ +: DATA_SZ];
        assign b_val = in_raw[(2*gi+1-N)*DATA_SZ +: DATA_SZ];
        assign a_idx = IDX_SZ'(2 * gi - N);
        assign b_idx = IDX_SZ'(2 * gi + 1 - N);
        assign a_vld = in_mask[2*gi-N];
        assign b_vld = in_mask[2*gi+1-N];
        assign mode  = in_mode;
      end else begin : g_inner
        assign a_val = val_q[2*gi];
        assign b_val = val_q[2*gi+1];
        assign a_idx = idx_q[2*gi];
        assign b_idx = idx_q[2*gi+1];
        assign a_vld = vld_q[2*gi];
        assign b_vld = vld_q[2*gi+1];
        assign mode  = mode_q[K-1];
      end

      extreme_val_node #(
        .DATA_SZ(DATA_SZ),
        .IDX_SZ (IDX_SZ),
        .SIGNED (SIGNED)
      ) u_node (
        .a_val_i(a_val),
        .a_idx_i(a_idx),
        .a_vld_i(a_vld),
        .b_val_i(b_val),
        .b_idx_i(b_idx),
        .b_vld_i(b_vld),
        .mode_i (mode),
        .y_val_o(y_val),
        .y_idx_o(y_idx),
        .y_vld_o(y_vld)
      );

      assign val_d[gi] = y_val;
      assign idx_d[gi] = y_idx;
      assign vld_d[gi] = y_vld;
    end
  endgenerate

  // Global stall: every stage, including bubbles, moves together only when adv is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sv_q   <= '0;
      mode_q <= '0;
      vld_q  <= '0;
      for (int n = 1; n < N; n++) begin
        val_q[n] <= '0;
        idx_q[n] <= '0;
      end
    end else if (adv) begin
      sv_q[1]   <= in_valid;
      mode_q[1] <= in_mode;
      for (int k = 2; k < LEVEL; k++) sv_q[k] <= sv_q[k-1];
      for (int k = 2; k <= MW; k++) mode_q[k] <= mode_q[k-1];
      vld_q <= vld_d;
      for (int n = 1; n < N; n++) begin
        val_q[n] <= val_d[n];
        idx_q[n] <= idx_d[n];
      end
    end
  end

endmodule

// File: tb/tb_extreme_val_pipe.sv
// Directed bench for extreme_val_pipe at LEVEL=3 (N=4, DATA_SZ=4); an unsigned and a signed instance share stimulus.
module tb_extreme_val_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_mode = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] in_raw = '0;
  logic [3:0]  in_mask = '0;

  logic       in_ready, out_valid, out_found;
  logic [3:0] out_result;
  logic [1:0] out_idx;
  logic       s_in_ready, s_out_valid, s_out_found;
  logic [3:0] s_out_result;
  logic [1:0] s_out_idx;

  // Result tuple {valid, found, idx[1:0], result[3:0]}
  logic [7:0] obs, s_obs;
  assign obs   = {out_valid, out_found, out_idx, out_result};
  assign s_obs = {s_out_valid, s_out_found, s_out_idx, s_out_result};

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  extreme_val_pipe #(.LEVEL(3), .DATA_SZ(4), .SIGNED(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_raw(in_raw), .in_mask(in_mask), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_idx(out_idx), .out_found(out_found)
  );

  extreme_val_pipe #(.LEVEL(3), .DATA_SZ(4), .SIGNED(1)) u_sdut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_raw(in_raw), .in_mask(in_mask), .in_mode(in_mode),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_result(s_out_result),
    .out_idx(s_out_idx), .out_found(s_out_found)
  );

  function automatic logic [15:0] ent(input logic [3:0] e0, e1, e2, e3);
    return {e3, e2, e1, e0};
  endfunction

  task automatic drive(input logic [15:0] raw, input logic [3:0] m, input logic md);
    in_valid = 1'b1;
    in_raw   = raw;
    in_mask  = m;
    in_mode  = md;
  endtask

  task automatic test_reset();
    logic [7:0] exp;
    rst_n = 1'b0;
    #12;
    exp = 8'h00;
    n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL reset_out: got %h want %h", obs, exp); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    $display("[TB] reset: out=%h in_ready=%b", obs, in_ready);
  endtask

  task automatic test_min();
    logic [7:0] exp;
    drive(ent(4'd3, 4'd9, 4'd1, 4'd7), 4'hF, 1'b0);
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL min_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL min_early: out_valid got %b want 0", out_valid); end
    @(negedge clk);
    exp = {1'b1, 1'b1, 2'd2, 4'd1};
    n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL min_basic: got %h want %h", obs, exp); end
    $display("[TB] min {3,9,1,7}: out=%h", obs);
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL min_popped: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    drive(ent(4'd3, 4'd9, 4'd1, 4'd7), 4'hF, 1'b1);
    @(negedge clk);
    drive(ent(4'd8, 4'd8, 4'd2, 4'd8), 4'hF, 1'b1);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_early: out_valid got %b want 0", out_valid); end
    @(negedge clk);
    in_valid = 1'b0;
    exp = {1'b1, 1'b1, 2'd1, 4'd9};
    n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL b2b_max1: got %h want %h", obs, exp); end
    $display("[TB] max {3,9,1,7}: out=%h", obs);
    @(negedge clk);
    exp = {1'b1, 1'b1, 2'd0, 4'd8};
    n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL b2b_tie: got %h want %h", obs, exp); end
    $display("[TB] max {8,8,2,8}: out=%h", obs);
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_mask();
    logic [7:0] exp;
    drive(ent(4'd3, 4'd9, 4'd1, 4'd7), 4'b1010, 1'b0);
    @(negedge clk);
    drive(ent(4'd3, 4'd9, 4'd1, 4'd7), 4'b0000, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    exp = {1'b1, 1'b1, 2'd3, 4'd7};
    n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL mask_partial: got %h want %h", obs, exp); end
    $display("[TB] mask 1010 min: out=%h", obs);
    @(negedge clk);
    exp = {1'b1, 1'b0, 2'd0, 4'd0};
    n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL mask_none: got %h want %h", obs, exp); end
    $display("[TB] mask 0000: out=%h", obs);
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mask_drain: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_signed();
    logic [7:0] exp;
    drive(ent(4'hF, 4'h2, 4'h8, 4'h0), 4'hF, 1'b0);
    @(negedge clk);
    drive(ent(4'hF, 4'h2, 4'h8, 4'h0), 4'hF, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    exp = {1'b1, 1'b1, 2'd2, 4'h8};
    n_tests++; if (s_obs !== exp) begin n_fail++; $display("FAIL signed_min: got %h want %h", s_obs, exp); end
    exp = {1'b1, 1'b1, 2'd3, 4'h0};
    n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL unsigned_min: got %h want %h", obs, exp); end
    $display("[TB] min {F,2,8,0}: signed=%h unsigned=%h", s_obs, obs);
    @(negedge clk);
    exp = {1'b1, 1'b1, 2'd1, 4'h2};
    n_tests++; if (s_obs !== exp) begin n_fail++; $display("FAIL signed_max: got %h want %h", s_obs, exp); end
    exp = {1'b1, 1'b1, 2'd0, 4'hF};
    n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL unsigned_max: got %h want %h", obs, exp); end
    $display("[TB] max {F,2,8,0}: signed=%h unsigned=%h", s_obs, obs);
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [7:0] exp;
    out_ready = 1'b0;
    drive(ent(4'd1, 4'd2, 4'd3, 4'd4), 4'hF, 1'b0);
    @(negedge clk);
    drive(ent(4'd5, 4'd6, 4'd7, 4'd0), 4'hF, 1'b1);
    @(negedge clk);
    drive(ent(4'd9, 4'd9, 4'd9, 4'd9), 4'hF, 1'b0);
    exp = {1'b1, 1'b1, 2'd0, 4'd1};
    for (int c = 0; c < 4; c++) begin
      #1;
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0", c, in_ready); end
      n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL bp_hold[%0d]: got %h want %h", c, obs, exp); end
      $display("[TB] held cycle %0d: out=%h in_ready=%b", c, obs, in_ready);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: in_ready got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    exp = {1'b1, 1'b1, 2'd2, 4'd7};
    n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL bp_second: got %h want %h", obs, exp); end
    $display("[TB] released 2nd: out=%h", obs);
    @(negedge clk);
    exp = {1'b1, 1'b1, 2'd0, 4'd9};
    n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL bp_third: got %h want %h", obs, exp); end
    $display("[TB] released 3rd: out=%h", obs);
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_reset_midop();
    logic [7:0] exp;
    out_ready = 1'b0;
    drive(ent(4'd3, 4'd9, 4'd1, 4'd7), 4'hF, 1'b0);
    @(negedge clk);
    drive(ent(4'd2, 4'd2, 4'd2, 4'd2), 4'hF, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midop_pre: out_valid got %b want 1", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    exp = 8'h00;
    n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL midop_async: got %h want %h", obs, exp); end
    n_tests++; if (s_out_valid !== 1'b0) begin n_fail++; $display("FAIL midop_async_s: out_valid got %b want 0", s_out_valid); end
    $display("[TB] async reset mid-op: out=%h", obs);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midop_dropped: out_valid got %b want 0", out_valid); end
    drive(ent(4'd4, 4'd6, 4'd5, 4'd2), 4'hF, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midop_early: out_valid got %b want 0", out_valid); end
    @(negedge clk);
    exp = {1'b1, 1'b1, 2'd1, 4'd6};
    n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL midop_new: got %h want %h", obs, exp); end
    $display("[TB] post-reset max {4,6,5,2}: out=%h", obs);
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midop_drain: out_valid got %b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_min();
    test_back_to_back();
    test_mask();
    test_signed();
    test_backpressure();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
